// File: rtl/line_transform_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : line_transform_engine_if
//  Description : Bash-side and video-memory-side handshake bundle for the
//                line transform engine. The engine uses the slave view; the
//                surrounding system (bash stream + line writer) uses master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface line_transform_engine_if #(
    parameter int LEN_W = 6
);
    // Bash -> engine
    logic              out_newASCII_ready;
    logic [7:0]        lineOut;
    logic [LEN_W-1:0]  out_lineLen;
    logic              lineOut_nextASCII;
    // Engine -> video memory
    logic              in_newASCII_ready;
    logic [7:0]        lineIn;
    logic              lineIn_nextASCII;
    logic              in_solved;
    logic              out_solved;

    modport slave (
        input  out_newASCII_ready,
        input  lineOut,
        input  out_lineLen,
        output lineOut_nextASCII,
        output in_newASCII_ready,
        output lineIn,
        input  lineIn_nextASCII,
        output in_solved,
        input  out_solved
    );

    modport master (
        output out_newASCII_ready,
        output lineOut,
        output out_lineLen,
        input  lineOut_nextASCII,
        input  in_newASCII_ready,
        input  lineIn,
        output lineIn_nextASCII,
        input  in_solved,
        output out_solved
    );
endinterface
`default_nettype wire

// File: rtl/line_transform_engine.sv
`default_nettype none
// ============================================================================
//  Module      : line_transform_engine
//  Description : Receives one 00-terminated line from bash into a buffer,
//                then presents one response line (echo / uppercase /
//                reversed / decimal length) to the video-memory writer.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_transform_engine #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [1:0]        mode,
    line_transform_engine_if.slave bus,
    output logic [LEN_W-1:0]       rx_len,
    output logic                   overflow,
    output logic                   busy
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RECV = 3'd1,
        S_GAP  = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [LEN_W-1:0]  rx_len_q, rx_len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic              ovf_q, ovf_d;
    logic              ack_q, ack_d;
    logic              rdy_q, rdy_d;
    logic              solved_q, solved_d;
    logic [7:0]        buf_q [0:MAX_LEN-1];

    logic              w_store;
    logic [LEN_W-1:0]  w_out_len;
    logic [LEN_W-1:0]  w_rd_idx;
    logic [7:0]        w_buf_byte;
    logic [7:0]        w_len8;
    logic [7:0]        w_tens;
    logic [7:0]        w_ones;
    logic [7:0]        w_char;
    logic              w_unused;

    // Length report is always two digits; other modes echo the stored count
    assign w_out_len = (mode_q == 2'd3) ? LEN_W'(2) : rx_len_q;

    // Next-state logic for the receive / present / complete sequence
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        rx_len_d = rx_len_q;
        idx_d    = idx_q;
        ovf_d    = ovf_q;
        ack_d    = 1'b0;
        rdy_d    = rdy_q;
        solved_d = solved_q;
        w_store  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.out_newASCII_ready) begin
                    mode_d   = mode;
                    rx_len_d = '0;
                    ovf_d    = 1'b0;
                    state_d  = S_RECV;
                end
            end
            S_RECV: begin
                // ack_q blocks a second capture of the same character
                if (bus.out_newASCII_ready && !ack_q) begin
                    ack_d = 1'b1;
                    if (bus.lineOut == 8'h00) begin
                        state_d = S_GAP;
                    end else if (rx_len_q < C_MAX_LEN) begin
                        w_store  = 1'b1;
                        rx_len_d = rx_len_q + LEN_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (!bus.out_newASCII_ready) begin
                    rdy_d   = 1'b1;
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (idx_q < w_out_len) begin
                    if (bus.lineIn_nextASCII) begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end else begin
                    // terminator has been visible for this one cycle
                    rdy_d    = 1'b0;
                    solved_d = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_solved) begin
                    solved_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= 2'd0;
            rx_len_q <= '0;
            idx_q    <= '0;
            ovf_q    <= 1'b0;
            ack_q    <= 1'b0;
            rdy_q    <= 1'b0;
            solved_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            rx_len_q <= rx_len_d;
            idx_q    <= idx_d;
            ovf_q    <= ovf_d;
            ack_q    <= ack_d;
            rdy_q    <= rdy_d;
            solved_q <= solved_d;
        end
    end

    // Line buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (w_store) begin
            buf_q[rx_len_q[IDX_W-1:0]] <= bus.lineOut;
        end
    end

    // Reverse mode reads from the tail; others read straight through
    assign w_rd_idx   = (mode_q == 2'd2) ? (rx_len_q - LEN_W'(1) - idx_q) : idx_q;
    assign w_buf_byte = buf_q[w_rd_idx[IDX_W-1:0]];
    assign w_len8     = 8'(rx_len_q);
    assign w_tens     = w_len8 / 8'd10;
    assign w_ones     = w_len8 % 8'd10;

    // Response character for the current index
    always_comb begin
        w_char = w_buf_byte;
        case (mode_q)
            2'd1: begin
                if (w_buf_byte >= 8'h61 && w_buf_byte <= 8'h7A) begin
                    w_char = w_buf_byte - 8'h20;
                end
            end
            2'd3: w_char = (idx_q == '0) ? (8'h30 + w_tens) : (8'h30 + w_ones);
            default: w_char = w_buf_byte;
        endcase
    end

    assign bus.lineIn            = (state_q == S_SEND && idx_q < w_out_len) ? w_char : 8'h00;
    assign bus.lineOut_nextASCII = ack_q;
    assign bus.in_newASCII_ready = rdy_q;
    assign bus.in_solved         = solved_q;
    assign rx_len                = rx_len_q;
    assign overflow              = ovf_q;
    assign busy                  = (state_q != S_IDLE);

    // Bash length is informational; upper read-index bits beyond the buffer are unused
    assign w_unused = ^{bus.out_lineLen, w_rd_idx};

endmodule
`default_nettype wire

// File: tb/tb_line_transform_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_transform_engine
//  Description : Directed self-checking bench. Instance A uses MAX_LEN=32,
//                instance B uses MAX_LEN=4 for the overflow scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_transform_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] s_mode;
    logic       sel;
    logic       s_ready;
    logic [7:0] s_char;
    logic       s_next;
    logic       s_solved;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    line_transform_engine_if #(.LEN_W(6)) ifa ();
    line_transform_engine_if #(.LEN_W(3)) ifb ();

    logic [5:0] rx_len_a;
    logic       ovf_a, busy_a;
    logic [2:0] rx_len_b;
    logic       ovf_b, busy_b;

    assign ifa.out_newASCII_ready = !sel && s_ready;
    assign ifa.lineOut            = s_char;
    assign ifa.out_lineLen        = '0;
    assign ifa.lineIn_nextASCII   = !sel && s_next;
    assign ifa.out_solved         = !sel && s_solved;
    assign ifb.out_newASCII_ready = sel && s_ready;
    assign ifb.lineOut            = s_char;
    assign ifb.out_lineLen        = '0;
    assign ifb.lineIn_nextASCII   = sel && s_next;
    assign ifb.out_solved         = sel && s_solved;

    line_transform_engine #(.MAX_LEN(32), .LEN_W(6)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode(s_mode), .bus(ifa.slave),
        .rx_len(rx_len_a), .overflow(ovf_a), .busy(busy_a)
    );

    line_transform_engine #(.MAX_LEN(4), .LEN_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode(s_mode), .bus(ifb.slave),
        .rx_len(rx_len_b), .overflow(ovf_b), .busy(busy_b)
    );

    wire       w_ack    = sel ? ifb.lineOut_nextASCII : ifa.lineOut_nextASCII;
    wire       w_rdy    = sel ? ifb.in_newASCII_ready : ifa.in_newASCII_ready;
    wire [7:0] w_char   = sel ? ifb.lineIn : ifa.lineIn;
    wire       w_solved = sel ? ifb.in_solved : ifa.in_solved;
    wire       w_busy   = sel ? busy_b : busy_a;
    wire       w_ovf    = sel ? ovf_b : ovf_a;
    wire [7:0] w_rxlen  = sel ? {5'b0, rx_len_b} : {2'b0, rx_len_a};

    // Bash side: present characters, advance on each acknowledge
    task automatic bash_send(input string s, output int acks);
        int pos = 0;
        acks     = 0;
        s_char   = (s.len() > 0) ? s[0] : 8'h00;
        s_ready  = 1'b1;
        for (int cyc = 0; cyc < 400 && s_ready; cyc++) begin
            @(posedge clk); #1;
            if (w_ack) begin
                acks++;
                if (pos >= s.len()) begin
                    s_ready = 1'b0;
                end else begin
                    pos++;
                    s_char = (pos < s.len()) ? s[pos] : 8'h00;
                end
            end
        end
        if (s_ready) begin
            checks++; errors++;
            $display("FAIL bash_send_timeout line=\"%s\" acks=%0d required terminator ack", s, acks);
            s_ready = 1'b0;
        end
    endtask

    // Video-memory side: collect characters until the 00 terminator
    task automatic vmem_recv(output string str, output bit term_ok);
        int cyc = 0;
        str     = "";
        term_ok = 1'b0;
        while (!w_rdy && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!w_rdy) begin
            checks++; errors++;
            $display("FAIL vmem_wait_ready actual=0 required=1");
            return;
        end
        for (int n = 0; n < 200; n++) begin
            if (w_char == 8'h00) begin
                @(posedge clk); #1;
                term_ok = !w_rdy && w_solved;
                return;
            end
            str    = $sformatf("%s%c", str, w_char);
            s_next = 1'b1;
            @(posedge clk); #1;
            s_next = 1'b0;
        end
        checks++; errors++;
        $display("FAIL vmem_recv_timeout got=\"%s\" required terminator", str);
    endtask

    // Acknowledge in_solved; reports whether the handshake completed cleanly
    task automatic finish_line(output bit ok);
        @(posedge clk); #1;
        ok       = w_solved && w_busy;
        s_solved = 1'b1;
        @(posedge clk); #1;
        s_solved = 1'b0;
        ok       = ok && !w_solved && !w_busy;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy_a, ifa.in_newASCII_ready, ifa.in_solved, ifa.lineOut_nextASCII, ovf_a} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags_a actual=%b required=00000",
                     {busy_a, ifa.in_newASCII_ready, ifa.in_solved, ifa.lineOut_nextASCII, ovf_a});
        end
        checks++;
        if (rx_len_a !== 6'd0 || ifa.lineIn !== 8'h00) begin
            errors++;
            $display("FAIL reset_len_a rx_len=%0d lineIn=%h required 0/00", rx_len_a, ifa.lineIn);
        end
        checks++;
        if ({busy_b, ifb.in_newASCII_ready, ifb.in_solved, ovf_b, rx_len_b} !== 7'b0) begin
            errors++;
            $display("FAIL reset_b actual=%b required=0000000",
                     {busy_b, ifb.in_newASCII_ready, ifb.in_solved, ovf_b, rx_len_b});
        end
    endtask

    task automatic test_echo();
        int acks; string str; bit tok, fok;
        sel = 1'b0; s_mode = 2'd0;
        bash_send("abc", acks);
        checks++;
        if (acks !== 4) begin errors++; $display("FAIL echo_acks actual=%0d required=4", acks); end
        vmem_recv(str, tok);
        checks++;
        if (str != "abc") begin errors++; $display("FAIL echo_data actual=\"%s\" required=\"abc\"", str); end
        checks++;
        if (tok !== 1'b1) begin errors++; $display("FAIL echo_term actual=%b required=1", tok); end
        checks++;
        if (w_rxlen !== 8'd3) begin errors++; $display("FAIL echo_rxlen actual=%0d required=3", w_rxlen); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (w_solved !== 1'b1) begin errors++; $display("FAIL echo_solved_hold actual=%b required=1", w_solved); end
        finish_line(fok);
        checks++;
        if (fok !== 1'b1) begin errors++; $display("FAIL echo_solved_ack actual=%b required=1", fok); end
    endtask

    task automatic test_upper_reverse();
        int acks; string str; bit tok, fok;
        sel = 1'b0; s_mode = 2'd1;
        bash_send("aZ9z", acks);
        vmem_recv(str, tok);
        finish_line(fok);
        checks++;
        if (str != "AZ9Z" || !tok || !fok || acks != 5) begin
            errors++;
            $display("FAIL upper actual=\"%s\" acks=%0d term=%b done=%b required=\"AZ9Z\" 5 1 1", str, acks, tok, fok);
        end
        s_mode = 2'd2;
        bash_send("abc", acks);
        vmem_recv(str, tok);
        finish_line(fok);
        checks++;
        if (str != "cba" || !tok || !fok) begin
            errors++;
            $display("FAIL reverse actual=\"%s\" term=%b done=%b required=\"cba\" 1 1", str, tok, fok);
        end
    endtask

    task automatic test_overflow();
        int acks; string str; bit tok, fok;
        sel = 1'b1; s_mode = 2'd0;
        bash_send("abcdef", acks);
        checks++;
        if (acks !== 7) begin errors++; $display("FAIL ovf_acks actual=%0d required=7", acks); end
        checks++;
        if (w_rxlen !== 8'd4 || w_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flags rx_len=%0d overflow=%b required 4/1", w_rxlen, w_ovf);
        end
        vmem_recv(str, tok);
        finish_line(fok);
        checks++;
        if (str != "abcd" || !tok || !fok) begin
            errors++;
            $display("FAIL ovf_data actual=\"%s\" term=%b done=%b required=\"abcd\" 1 1", str, tok, fok);
        end
        checks++;
        if (w_ovf !== 1'b1 || w_rxlen !== 8'd4) begin
            errors++;
            $display("FAIL ovf_sticky overflow=%b rx_len=%0d required 1/4", w_ovf, w_rxlen);
        end
        sel = 1'b0;
    endtask

    task automatic test_length_and_empty();
        int acks; string str; bit tok, fok;
        sel = 1'b0; s_mode = 2'd3;
        bash_send("abcdefghijkl", acks);
        vmem_recv(str, tok);
        finish_line(fok);
        checks++;
        if (str != "12" || !tok || !fok) begin
            errors++;
            $display("FAIL len12 actual=\"%s\" term=%b done=%b required=\"12\" 1 1", str, tok, fok);
        end
        bash_send("", acks);
        vmem_recv(str, tok);
        finish_line(fok);
        checks++;
        if (str != "00" || !tok || !fok || acks != 1) begin
            errors++;
            $display("FAIL len_empty actual=\"%s\" acks=%0d required=\"00\" 1", str, acks);
        end
        s_mode = 2'd0;
        bash_send("", acks);
        vmem_recv(str, tok);
        checks++;
        if (str != "" || !tok) begin
            errors++;
            $display("FAIL echo_empty actual=\"%s\" term=%b required=\"\" 1", str, tok);
        end
        finish_line(fok);
        checks++;
        if (!fok || w_rxlen !== 8'd0) begin
            errors++;
            $display("FAIL echo_empty_done done=%b rx_len=%0d required 1/0", fok, w_rxlen);
        end
    endtask

    task automatic test_back_to_back();
        int acks, early; string str; bit tok, fok;
        sel = 1'b0; s_mode = 2'd0;
        bash_send("xy", acks);
        vmem_recv(str, tok);
        s_ready = 1'b1; s_char = "q";
        early = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (w_ack) early++;
        end
        checks++;
        if (early !== 0 || w_solved !== 1'b1) begin
            errors++;
            $display("FAIL done_ignore acks=%0d solved=%b required 0/1", early, w_solved);
        end
        s_solved = 1'b1;
        @(posedge clk); #1;
        s_solved = 1'b0;
        bash_send("q", acks);
        vmem_recv(str, tok);
        finish_line(fok);
        checks++;
        if (str != "q" || acks != 2 || !tok || !fok) begin
            errors++;
            $display("FAIL second_line actual=\"%s\" acks=%0d required=\"q\" 2", str, acks);
        end
    endtask

    task automatic test_async_reset();
        int acks, cyc; string str; bit tok, fok;
        sel = 1'b0; s_mode = 2'd0;
        bash_send("hello", acks);
        cyc = 0;
        while (!w_rdy && cyc < 20) begin @(posedge clk); #1; cyc++; end
        for (int i = 0; i < 2; i++) begin
            s_next = 1'b1;
            @(posedge clk); #1;
            s_next = 1'b0;
        end
        checks++;
        if (w_char !== 8'h6C) begin errors++; $display("FAIL mid_send_char actual=%h required=6c", w_char); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({w_rdy, w_solved, w_busy} !== 3'b000 || w_rxlen !== 8'd0) begin
            errors++;
            $display("FAIL async_reset rdy/solved/busy=%b rx_len=%0d required 000/0",
                     {w_rdy, w_solved, w_busy}, w_rxlen);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bash_send("ok", acks);
        vmem_recv(str, tok);
        finish_line(fok);
        checks++;
        if (str != "ok" || !tok || !fok) begin
            errors++;
            $display("FAIL after_reset actual=\"%s\" term=%b done=%b required=\"ok\" 1 1", str, tok, fok);
        end
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; s_mode = 2'd0;
        s_ready = 1'b0; s_char = 8'h00; s_next = 1'b0; s_solved = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_echo();
        test_upper_reverse();
        test_overflow();
        test_length_and_empty();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
